// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller: Moore FSM sequencing the shared-memory datapath,
// with a memory handshake on fetch/load/store and an internal ALU decoder.
//
// state | meaning
// ------+---------------------------------------------------------------
//   0   | FETCH    read instruction at PC, PC <= PC+4 when memory is ready
//   1   | DECODE   read registers, precompute branch target into ALUOut
//   2   | MEMADR   effective address = A + SignImm
//   3   | MEMRD    read data memory at ALUOut, wait for mem_ready
//   4   | MEMWB    write MDR to rt
//   5   | MEMWR    write B to memory at ALUOut, wait for mem_ready
//   6   | EXECUTE  R-type ALU operation on A, B
//   7   | ALUWB    write ALUOut to rd
//   8   | BRANCH   compare A, B; load branch target when equal
//   9   | ADDIEXE  A + SignImm
//  10   | ADDIWB   write ALUOut to rt
//  11   | JUMP     load jump target
// 12-15 | unused, recover to FETCH
module multicycle_controller (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic [2:0] ALUControl,
   output logic       illegal,
   output logic [3:0] state
);

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_EXECUTE = 4'd6;
   localparam logic [3:0] S_ALUWB   = 4'd7;
   localparam logic [3:0] S_BRANCH  = 4'd8;
   localparam logic [3:0] S_ADDIEXE = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JUMP    = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   logic [3:0] state_nxt;
   logic [1:0] aluop;
   logic       funct_ok;
   logic       op_ok;
   logic       mem_req_raw;
   logic       irwrite_raw;
   logic       pcen_raw;

   // Legal-instruction check used by DECODE
   always_comb begin
      funct_ok = 1'b0;
      case (funct)
         6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
         default: funct_ok = 1'b0;
      endcase
      op_ok = 1'b0;
      case (opcode)
         OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_ok = 1'b1;
         OP_RTYPE:                           op_ok = funct_ok;
         default:                            op_ok = 1'b0;
      endcase
   end

   // Next-state logic; memory states hold until mem_ready
   always_comb begin
      state_nxt = state;
      case (state)
         S_FETCH:   state_nxt = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if (!op_ok)                 state_nxt = S_FETCH;
            else if (opcode == OP_RTYPE) state_nxt = S_EXECUTE;
            else if (opcode == OP_BEQ)   state_nxt = S_BRANCH;
            else if (opcode == OP_ADDI)  state_nxt = S_ADDIEXE;
            else if (opcode == OP_J)     state_nxt = S_JUMP;
            else                         state_nxt = S_MEMADR;
         end
         S_MEMADR:  state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:   state_nxt = S_FETCH;
         S_MEMWR:   state_nxt = mem_ready ? S_FETCH : S_MEMWR;
         S_EXECUTE: state_nxt = S_ALUWB;
         S_ALUWB:   state_nxt = S_FETCH;
         S_BRANCH:  state_nxt = S_FETCH;
         S_ADDIEXE: state_nxt = S_ADDIWB;
         S_ADDIWB:  state_nxt = S_FETCH;
         S_JUMP:    state_nxt = S_FETCH;
         default:   state_nxt = S_FETCH;
      endcase
   end

   // State register; reset forces FETCH immediately, abandoning any access
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_FETCH;
      else          state <= state_nxt;
   end

   // Moore output decode; only the handshake strobes and branch PCEn look at inputs
   always_comb begin
      mem_req_raw = 1'b0;
      irwrite_raw = 1'b0;
      pcen_raw    = 1'b0;
      IorD        = 1'b0;
      MemWrite    = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSrc       = 2'b00;
      aluop       = ALUOP_ADD;
      illegal     = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req_raw = 1'b1;
            ALUSrcB     = 2'b01;
            irwrite_raw = mem_ready;
            pcen_raw    = mem_ready;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            illegal = ~op_ok;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            mem_req_raw = 1'b1;
            IorD        = 1'b1;
         end
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         S_MEMWR: begin
            mem_req_raw = 1'b1;
            IorD        = 1'b1;
            MemWrite    = 1'b1;
         end
         S_EXECUTE: begin
            ALUSrcA = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA  = 1'b1;
            aluop    = ALUOP_SUB;
            PCSrc    = 2'b01;
            pcen_raw = zero;
         end
         S_ADDIEXE: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_ADDIWB: RegWrite = 1'b1;
         S_JUMP: begin
            PCSrc    = 2'b10;
            pcen_raw = 1'b1;
         end
         default: ;
      endcase
   end

   // Hold memory and PC/IR strobes off while reset is asserted
   assign mem_req = mem_req_raw & reset_n;
   assign IRWrite = irwrite_raw & reset_n;
   assign PCEn    = pcen_raw & reset_n;

   // ALU decoder; unsupported funct falls back to add (already flagged in DECODE)
   always_comb begin
      ALUControl = 3'b010;
      case (aluop)
         ALUOP_SUB: ALUControl = 3'b110;
         ALUOP_FUNCT: begin
            case (funct)
               6'b100010: ALUControl = 3'b110;
               6'b100100: ALUControl = 3'b000;
               6'b100101: ALUControl = 3'b001;
               6'b101010: ALUControl = 3'b111;
               default:   ALUControl = 3'b010;
            endcase
         end
         default: ALUControl = 3'b010;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-cycle expected outputs are queued with
// their stimulus and compared as the controller steps through each instruction.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSrc;
   logic       PCEn, illegal;
   logic [2:0] ALUControl;
   logic [3:0] state;

   int total = 0;
   int bad   = 0;

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

   typedef struct {
      logic        mr;
      logic        z;
      logic [5:0]  op;
      logic [5:0]  fn;
      logic [20:0] exp;
      logic [20:0] mask;
   } item_t;

   item_t sbq[$];

   multicycle_controller dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn),
      .ALUControl(ALUControl), .illegal(illegal), .state(state)
   );

   always #5 clk = ~clk;

   logic [20:0] obs;
   assign obs = {state, mem_req, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                 ALUSrcA, ALUSrcB, PCSrc, PCEn, ALUControl, illegal};

   // Reference outputs for one cycle, written from the per-state output table
   function automatic logic [20:0] ref_out(input logic [3:0] st, input logic mr, input logic z,
                                           input logic [5:0] op, input logic [5:0] fn);
      logic mreq, iord, mw, irw, rd, m2r, rw, sa, pe, il, fn_ok;
      logic [1:0] sb, ps;
      logic [2:0] ac;
      {mreq, iord, mw, irw, rd, m2r, rw, sa, pe, il} = '0;
      sb = 2'b00; ps = 2'b00; ac = 3'b010;
      fn_ok = (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
              (fn == 6'b100101) || (fn == 6'b101010);
      case (st)
         4'd0:  begin mreq = 1; sb = 2'b01; irw = mr; pe = mr; end
         4'd1:  begin
                   sb = 2'b11;
                   il = !((op == LW) || (op == SW) || (op == BEQ) || (op == ADDI) ||
                          (op == JMP) || ((op == RT) && fn_ok));
                end
         4'd2:  begin sa = 1; sb = 2'b10; end
         4'd3:  begin mreq = 1; iord = 1; end
         4'd4:  begin m2r = 1; rw = 1; end
         4'd5:  begin mreq = 1; iord = 1; mw = 1; end
         4'd6:  begin
                   sa = 1;
                   case (fn)
                      6'b100010: ac = 3'b110;
                      6'b100100: ac = 3'b000;
                      6'b100101: ac = 3'b001;
                      6'b101010: ac = 3'b111;
                      default:   ac = 3'b010;
                   endcase
                end
         4'd7:  begin rd = 1; rw = 1; end
         4'd8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
         4'd9:  begin sa = 1; sb = 2'b10; end
         4'd10: rw = 1;
         4'd11: begin ps = 2'b10; pe = 1; end
         default: ;
      endcase
      return {st, mreq, iord, mw, irw, rd, m2r, rw, sa, sb, ps, pe, ac, il};
   endfunction

   // Queue one cycle of stimulus together with the outputs it must produce
   task automatic push(input logic [3:0] st, input logic mr, input logic z,
                       input logic [5:0] op, input logic [5:0] fn);
      item_t it;
      it.mr = mr; it.z = z; it.op = op; it.fn = fn;
      it.exp = ref_out(st, mr, z, op, fn);
      it.mask = '1;
      // ALU function is only defined where the state table names an ALU operation
      if (!(st inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd8, 4'd9})) it.mask[3:1] = 3'b000;
      sbq.push_back(it);
   endtask

   task automatic test_reset();
      reset_n = 1'b0; opcode = SW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({state, mem_req, IRWrite, PCEn, MemWrite, ALUSrcB} !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01}) begin
         bad++;
         $display("FAIL reset_hold got st=%0d req=%b irw=%b pcen=%b mw=%b srcb=%b need 0 0 0 0 0 01",
                  state, mem_req, IRWrite, PCEn, MemWrite, ALUSrcB);
      end
      reset_n = 1'b1;
      #1;
      total++;
      if ({state, mem_req} !== {4'd0, 1'b1}) begin
         bad++;
         $display("FAIL reset_release got st=%0d req=%b need 0 1", state, mem_req);
      end
      // walk a store into MEMWR and stall there
      repeat (3) @(negedge clk);
      mem_ready = 1'b0;
      #1;
      total++;
      if ({state, MemWrite} !== {4'd5, 1'b1}) begin
         bad++;
         $display("FAIL reach_memwr got st=%0d mw=%b need 5 1", state, MemWrite);
      end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({state, MemWrite, mem_req} !== {4'd0, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_mid_memwr got st=%0d mw=%b req=%b need 0 0 0", state, MemWrite, mem_req);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_lw();
      item_t it;
      int irw_cnt = 0;
      push(0, 1, 0, LW, 0); push(1, 1, 0, LW, 0); push(2, 1, 0, LW, 0);
      push(3, 1, 0, LW, 0); push(4, 1, 0, LW, 0); push(0, 0, 0, LW, 0);
      while (sbq.size() > 0) begin
         it = sbq.pop_front();
         mem_ready = it.mr; zero = it.z; opcode = it.op; funct = it.fn;
         #1;
         irw_cnt += int'(IRWrite);
         total++;
         if ((obs & it.mask) !== (it.exp & it.mask)) begin
            bad++;
            $display("FAIL lw got=%h need=%h", obs & it.mask, it.exp & it.mask);
         end
         @(negedge clk);
      end
      total++;
      if (irw_cnt !== 1) begin
         bad++;
         $display("FAIL lw_irwrite_count got %0d need 1", irw_cnt);
      end
   endtask

   task automatic test_sw_stall();
      item_t it;
      int mw_cnt = 0;
      int rw_cnt = 0;
      push(0, 1, 0, SW, 0); push(1, 0, 0, SW, 0); push(2, 0, 0, SW, 0);
      push(5, 0, 0, SW, 0); push(5, 0, 0, SW, 0); push(5, 0, 0, SW, 0);
      push(5, 1, 0, SW, 0); push(0, 0, 0, SW, 0);
      while (sbq.size() > 0) begin
         it = sbq.pop_front();
         mem_ready = it.mr; zero = it.z; opcode = it.op; funct = it.fn;
         #1;
         mw_cnt += int'(MemWrite);
         rw_cnt += int'(RegWrite);
         total++;
         if ((obs & it.mask) !== (it.exp & it.mask)) begin
            bad++;
            $display("FAIL sw got=%h need=%h", obs & it.mask, it.exp & it.mask);
         end
         @(negedge clk);
      end
      total++;
      if ({mw_cnt, rw_cnt} !== {32'd4, 32'd0}) begin
         bad++;
         $display("FAIL sw_counts got mw=%0d rw=%0d need mw=4 rw=0", mw_cnt, rw_cnt);
      end
   endtask

   task automatic test_rtype();
      item_t it;
      push(0, 1, 0, RT, 6'b101010); push(6, 1, 0, RT, 6'b101010); push(7, 1, 0, RT, 6'b101010);
      push(0, 1, 0, RT, 6'b100010); push(1, 1, 0, RT, 6'b100010); push(6, 1, 0, RT, 6'b100010);
      push(7, 0, 0, RT, 6'b100010);
      push(0, 1, 0, RT, 6'b100101); push(1, 1, 0, RT, 6'b100101); push(6, 1, 0, RT, 6'b100101);
      push(7, 1, 0, RT, 6'b100101); push(0, 0, 0, RT, 6'b100101);
      // the DECODE cycle of the first instruction is inserted to keep the trace contiguous
      sbq.insert(1, sbq[0]);
      sbq[1].exp = ref_out(1, 1, 0, RT, 6'b101010);
      while (sbq.size() > 0) begin
         it = sbq.pop_front();
         mem_ready = it.mr; zero = it.z; opcode = it.op; funct = it.fn;
         #1;
         total++;
         if ((obs & it.mask) !== (it.exp & it.mask)) begin
            bad++;
            $display("FAIL rtype got=%h need=%h", obs & it.mask, it.exp & it.mask);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_beq_jump();
      item_t it;
      push(0, 1, 1, BEQ, 0); push(1, 1, 1, BEQ, 0); push(8, 1, 1, BEQ, 0);
      push(0, 1, 0, BEQ, 0); push(1, 1, 0, BEQ, 0); push(8, 1, 0, BEQ, 0);
      push(0, 1, 0, JMP, 0); push(1, 1, 0, JMP, 0); push(11, 0, 0, JMP, 0);
      push(0, 0, 0, JMP, 0);
      while (sbq.size() > 0) begin
         it = sbq.pop_front();
         mem_ready = it.mr; zero = it.z; opcode = it.op; funct = it.fn;
         #1;
         total++;
         if ((obs & it.mask) !== (it.exp & it.mask)) begin
            bad++;
            $display("FAIL beq_j got=%h need=%h", obs & it.mask, it.exp & it.mask);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_illegal();
      item_t it;
      int il_cnt = 0;
      push(0, 1, 0, 6'b111111, 0); push(1, 1, 0, 6'b111111, 0);
      push(0, 1, 0, RT, 6'b000111); push(1, 1, 0, RT, 6'b000111);
      push(0, 0, 0, RT, 6'b000111);
      while (sbq.size() > 0) begin
         it = sbq.pop_front();
         mem_ready = it.mr; zero = it.z; opcode = it.op; funct = it.fn;
         #1;
         il_cnt += int'(illegal);
         total++;
         if ((obs & it.mask) !== (it.exp & it.mask)) begin
            bad++;
            $display("FAIL illegal got=%h need=%h", obs & it.mask, it.exp & it.mask);
         end
         @(negedge clk);
      end
      total++;
      if (il_cnt !== 2) begin
         bad++;
         $display("FAIL illegal_pulses got %0d need 2", il_cnt);
      end
   endtask

   task automatic test_back_to_back();
      item_t it;
      push(0, 0, 0, ADDI, 0); push(0, 0, 0, ADDI, 0); push(0, 1, 0, ADDI, 0);
      push(1, 0, 0, ADDI, 0); push(9, 1, 0, ADDI, 0); push(10, 1, 0, ADDI, 0);
      push(0, 1, 0, LW, 0); push(1, 1, 0, LW, 0); push(2, 1, 0, LW, 0);
      push(3, 0, 0, LW, 0); push(3, 0, 0, LW, 0); push(3, 1, 0, LW, 0);
      push(4, 0, 0, LW, 0); push(0, 0, 0, LW, 0);
      while (sbq.size() > 0) begin
         it = sbq.pop_front();
         mem_ready = it.mr; zero = it.z; opcode = it.op; funct = it.fn;
         #1;
         total++;
         if ((obs & it.mask) !== (it.exp & it.mask)) begin
            bad++;
            $display("FAIL b2b got=%h need=%h", obs & it.mask, it.exp & it.mask);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_stall();
      test_rtype();
      test_beq_jump();
      test_illegal();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

- Sequences the multicycle MIPS datapath: one shared memory, one ALU, IR/MDR/A/B/ALUOut registers.
- Implements a Moore FSM plus an internal ALU decoder that drives every datapath mux select, write enable and the ALU function for lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.
- Adds a memory handshake, so fetch and data accesses stall until the shared memory responds.
- Sits beside the datapath in the multicycle top level; the single-cycle controller is not replaced.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[31:26], taken from the IR.
- funct  in  6  instr[5:0], taken from the IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access requested.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR load enable.
- RegDst  out  1  register write address select: 0 = rt, 1 = rd.
- MemtoReg  out  1  register write data select: 0 = ALUOut, 1 = MDR.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU operand A: 0 = PC, 1 = A.
- ALUSrcB  out  2  ALU operand B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- PCSrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- PCEn  out  1  PC load enable.
- ALUControl  out  3  ALU function.
- illegal  out  1  one-cycle pulse when DECODE sees an unsupported opcode or funct.
- state  out  4  current state, for debug.

## Operation
States and encodings:
- FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXE=9, ADDIWB=10, JUMP=11. Codes 12–15 are unreachable and recover to FETCH.

Per-state behaviour. Any output not listed for a state is 0.
- FETCH: mem_req=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add, PCSrc=00. IRWrite=1 and PCEn=1 only in the cycle mem_ready=1; that cycle goes to DECODE, otherwise stay in FETCH.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add (precomputes the branch target). Next state by opcode:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 (R-type) → EXECUTE.
  - 000100 (beq) → BRANCH.
  - 001000 (addi) → ADDIEXE.
  - 000010 (j) → JUMP.
  - Any other opcode, or an R-type funct outside the five supported → pulse illegal, go to FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=add. lw → MEMRD, sw → MEMWR.
- MEMRD: mem_req=1, IorD=1. Stay until mem_ready, then → MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 → FETCH.
- MEMWR: mem_req=1, IorD=1, MemWrite=1, held for the whole stall. When mem_ready → FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=funct → ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCSrc=01, PCEn=zero → FETCH.
- ADDIEXE: ALUSrcA=1, ALUSrcB=10, ALUOp=add → ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 → FETCH.
- JUMP: PCSrc=10, PCEn=1 → FETCH.

ALU decoder (combinational):
- ALUOp=add → 010.
- ALUOp=sub → 110.
- ALUOp=funct → add 100000 → 010, sub 100010 → 110, and 100100 → 000, or 100101 → 001, slt 101010 → 111.
- Unknown funct → 010 (and illegal was already flagged in DECODE).

## Timing
- All outputs are decoded from the registered state; mem_ready-qualified outputs and PCEn in BRANCH are additionally combinational in their input.
- Reset: reset_n low → state=FETCH asynchronously. While in reset, mem_req=0, IRWrite=0 and PCEn=0 (gated). All other outputs take FETCH values.
  - First fetch request is in the first cycle after reset_n rises.
  - Reset mid-access abandons the access; MemWrite drops immediately.
- Cycles per instruction with mem_ready tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds exactly one cycle. No output changes during a stall.
- mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- Exactly one PCEn pulse per fetch. At most one additional PCEn, in BRANCH (taken) or JUMP.

## Test plan
- Reset: assert reset_n=0 mid-MEMWR → state=0 and MemWrite=0 in the same cycle. After release, FETCH with mem_req=1.
- lw, mem_ready=1: state trace 0,1,2,3,4,0. RegWrite=1 only in state 4, with MemtoReg=1. IRWrite/PCEn only in cycle 1.
- sw with mem_ready low 3 cycles in MEMWR: MemWrite high for 4 consecutive cycles, then FETCH. RegWrite never set.
- R-type:
  - funct 101010: ALUControl=111 in EXECUTE, RegDst=1 in ALUWB.
  - funct 100010: ALUControl=110.
- beq: zero=1 → PCEn=1 with PCSrc=01 in BRANCH. zero=0 → PCEn=0. Both cases return to FETCH in 3 cycles.
- j: PCSrc=10, PCEn=1 in cycle 3. Opcode 111111 → illegal=1 for one cycle in DECODE, back to FETCH, no write enables asserted.
